// File: rtl/mskaes_job_scheduler_if.sv
// Request, response, core and PRNG signals of the masked AES job scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface mskaes_job_scheduler_if #(
  parameter int d = 2
);
  localparam int W = 128 * d;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_pt0;
  logic [W-1:0] req_pt1;
  logic [W-1:0] req_key0;
  logic [W-1:0] req_key1;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic         rsp_err;
  logic [W-1:0] rsp_data;

  logic         core_nrst;
  logic         core_valid_in;
  logic         core_ready;
  logic         core_cipher_valid;
  logic [W-1:0] core_sh_plaintext;
  logic [W-1:0] core_sh_key;
  logic [W-1:0] core_sh_ciphertext;

  logic         prng_start_reseed;
  logic         prng_out_valid;
  logic         busy;

  modport master (
    input  req_valid, req_pt0, req_pt1, req_key0, req_key1,
    input  rsp_ready,
    input  core_ready, core_cipher_valid, core_sh_ciphertext,
    input  prng_out_valid,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
    output core_nrst, core_valid_in, core_sh_plaintext, core_sh_key,
    output prng_start_reseed, busy
  );

  modport slave (
    output req_valid, req_pt0, req_pt1, req_key0, req_key1,
    output rsp_ready,
    output core_ready, core_cipher_valid, core_sh_ciphertext,
    output prng_out_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
    input  core_nrst, core_valid_in, core_sh_plaintext, core_sh_key,
    input  prng_start_reseed, busy
  );
endinterface

// File: rtl/mskaes_job_scheduler.sv
// Reseed/warm-up sequencing, round-robin arbitration and one-at-a-time
// launch of encryptions on a shared masked AES-128 core, with watchdog recovery.
module mskaes_job_scheduler #(
  parameter int d            = 2,
  parameter int WARMUP       = 30,
  parameter int RESEED_EVERY = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic clk,
  input  logic rst,
  mskaes_job_scheduler_if.master bus
);

  localparam int W  = 128 * d;
  localparam int WW = $clog2(WARMUP + 1);
  localparam int EW = $clog2(RESEED_EVERY + 1);

  localparam logic [WW-1:0] WARM_LIMIT = WW'(WARMUP - 1);
  localparam logic [EW-1:0] ENC_LIMIT  = EW'(RESEED_EVERY);
  localparam logic [7:0]    WD_LIMIT   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESEED,
    S_WARM,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RECOVER
  } state_e;

  state_e        state_q;
  logic [WW-1:0] warm_q;
  logic [7:0]    wd_q;
  logic [EW-1:0] enc_q;
  logic [1:0]    rec_q;
  logic          last_q;
  logic          abort_q;

  logic [1:0]    req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic          rsp_err_q;
  logic [W-1:0]  rsp_data_q;
  logic [W-1:0]  pt_q;
  logic [W-1:0]  key_q;
  logic          core_nrst_q;
  logic          core_valid_in_q;
  logic          prng_start_reseed_q;
  logic          busy_q;

  logic          grant_d;
  logic [W-1:0]  pt_d;
  logic [W-1:0]  key_d;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    grant_d = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant_d = ~last_q;
    end else if (!bus.req_valid[0]) begin
      grant_d = 1'b1;
    end
    pt_d  = grant_d ? bus.req_pt1  : bus.req_pt0;
    key_d = grant_d ? bus.req_key1 : bus.req_key0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_RESEED;
      warm_q              <= '0;
      wd_q                <= '0;
      enc_q               <= '0;
      rec_q               <= '0;
      last_q              <= 1'b1;
      abort_q             <= 1'b0;
      req_ready_q         <= '0;
      rsp_valid_q         <= 1'b0;
      rsp_id_q            <= 1'b0;
      rsp_err_q           <= 1'b0;
      rsp_data_q          <= '0;
      pt_q                <= '0;
      key_q               <= '0;
      core_nrst_q         <= 1'b0;
      core_valid_in_q     <= 1'b0;
      prng_start_reseed_q <= 1'b0;
      busy_q              <= 1'b0;
    end else begin
      req_ready_q         <= '0;
      core_valid_in_q     <= 1'b0;
      prng_start_reseed_q <= 1'b0;

      case (state_q)
        S_RESEED: begin
          prng_start_reseed_q <= 1'b1;
          core_nrst_q         <= 1'b1;
          warm_q              <= '0;
          busy_q              <= 1'b1;
          state_q             <= S_WARM;
        end

        S_WARM: begin
          if (warm_q >= WARM_LIMIT && bus.prng_out_valid) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (warm_q != '1) begin
            warm_q <= warm_q + WW'(1);
          end
        end

        S_IDLE: begin
          if (|bus.req_valid) begin
            req_ready_q <= grant_d ? 2'b10 : 2'b01;
            last_q      <= grant_d;
            rsp_id_q    <= grant_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (bus.core_ready) begin
            core_valid_in_q <= 1'b1;
            wd_q            <= '0;
            state_q         <= S_WAIT;
          end
        end

        // A result arriving on the expiry cycle still counts as success.
        S_WAIT: begin
          if (bus.core_cipher_valid) begin
            rsp_data_q  <= bus.core_sh_ciphertext;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            enc_q       <= enc_q + EW'(1);
            state_q     <= S_RESP;
          end else if (wd_q >= WD_LIMIT) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            abort_q     <= 1'b1;
            state_q     <= S_RESP;
          end else if (wd_q != '1) begin
            wd_q <= wd_q + 8'd1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (abort_q) begin
              abort_q     <= 1'b0;
              core_nrst_q <= 1'b0;
              rec_q       <= '0;
              state_q     <= S_RECOVER;
            end else if (enc_q == ENC_LIMIT) begin
              enc_q   <= '0;
              state_q <= S_RESEED;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        // The core reset is held for three cycles before reseeding.
        S_RECOVER: begin
          if (rec_q == 2'd2) begin
            core_nrst_q <= 1'b1;
            state_q     <= S_RESEED;
          end else begin
            rec_q <= rec_q + 2'd1;
          end
        end

        default: begin
          state_q <= S_RESEED;
        end
      endcase
    end
  end

  assign bus.req_ready         = req_ready_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_id            = rsp_id_q;
  assign bus.rsp_err           = rsp_err_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.core_nrst         = core_nrst_q;
  assign bus.core_valid_in     = core_valid_in_q;
  assign bus.core_sh_plaintext = pt_q;
  assign bus.core_sh_key       = key_q;
  assign bus.prng_start_reseed = prng_start_reseed_q;
  assign bus.busy              = busy_q;

endmodule

// File: doc/mskaes_job_scheduler.md
# mskaes_job_scheduler

Sequencing and arbitration controller placed in front of the masked AES-128 wrapper (`wrapper_aes128`: round-based DOM core plus PRNG). It runs the PRNG reseed and warm-up after reset, shares the single core between two requesters by round-robin, and launches one encryption at a time. It then returns the shared ciphertext to the requester through a valid/ready response channel. It also forces a periodic reseed and recovers from a hung core with a watchdog.

## Interface
- `d`, 2: number of shares. Every shared bus is 128·d bits, bit-interleaved: bit i's shares are at `[d*i +: d]`.
- `WARMUP`, 30: minimum cycles between the reseed pulse and the first issue.
- `RESEED_EVERY`, 16: number of completed encryptions between forced reseeds (≥1).
- `TIMEOUT`, 255: maximum cycles spent in WAIT before abort (8-bit counter).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  one-hot grant/accept pulse.
- `req_pt0`, `req_pt1`  in  128·d  shared plaintext per requester.
- `req_key0`, `req_key1`  in  128·d  shared key per requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  index of the requester being served.
- `rsp_err`  out  1  1 = watchdog abort; `rsp_data` is zero.
- `rsp_data`  out  128·d  shared ciphertext.
- `core_nrst`  out  1  active-low reset to the wrapper.
- `core_valid_in`  out  1  start pulse to the core.
- `core_ready`  in  1  core idle.
- `core_cipher_valid`  in  1  ciphertext valid.
- `core_sh_plaintext`, `core_sh_key`  out  128·d  operands, held stable from grant until completion.
- `core_sh_ciphertext`  in  128·d  core result.
- `prng_start_reseed`  out  1  reseed pulse.
- `prng_out_valid`  in  1  PRNG ready.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - RESEED: drives `prng_start_reseed`=1 for exactly one cycle, clears the warm-up counter, then goes to WARM.
  - WARM: counts cycles. Goes to IDLE when count ≥ WARMUP-1 and `prng_out_valid`=1. If `prng_out_valid` is low, it waits indefinitely.
  - IDLE: arbitrates among requests.
    - If any `req_valid` is set: grant one requester, pulse its `req_ready` for one cycle, latch its pt/key into the operand registers, latch `rsp_id`, then go to ISSUE.
    - Round-robin: with both valid, grant the one not granted last. After reset, requester 0 has priority.
  - ISSUE: asserts `core_valid_in` for exactly one cycle, in the first cycle where `core_ready`=1, then goes to WAIT and clears the watchdog.
  - WAIT: on `core_cipher_valid`=1, captures `core_sh_ciphertext` into `rsp_data`, sets `rsp_err`=0, increments the encryption counter, and goes to RESP. If the watchdog reaches TIMEOUT first: sets `rsp_err`=1, sets `rsp_data`=0, goes to RESP, and marks abort.
  - RESP: holds `rsp_valid`=1 with stable id/data/err until `rsp_ready`=1, then exits:
    - to RECOVER if abort is marked;
    - to RESEED if the encryption counter equals RESEED_EVERY (counter then cleared);
    - otherwise to IDLE.
  - RECOVER: drives `core_nrst`=0 for 3 cycles, then goes to RESEED.
- Operand registers change only in the IDLE grant cycle.
- `req_valid` that arrives while busy is not accepted. The requester must hold it.

## Timing
- During `rst`=1:
  - state goes to RESEED.
  - `core_nrst`=0; all other outputs are 0.
  - operand registers, `rsp_data` and all counters are 0.
  - last-grant pointer is 1.
- First cycle after `rst` falls: `core_nrst`=1 and `prng_start_reseed`=1.
- Minimum path from reset to first issue is 1 + WARMUP + 1 (grant) cycles. `core_valid_in` is asserted the cycle after grant if `core_ready`=1.
- `rsp_valid` rises the cycle after `core_cipher_valid` is sampled.
- Back-to-back: after a `rsp_ready` handshake, IDLE can grant on the next cycle.
- `rsp_ready` and a new `req_valid` in the same cycle: the response completes first; the grant happens in the following IDLE cycle.
- A `core_cipher_valid` in the same cycle as the watchdog expiring counts as success.
- `rst` asserted in any state aborts immediately. No response is emitted for in-flight work, and there is no `req_ready` pulse.
- Watchdog and warm-up counters saturate; they never wrap.

## Test plan
- Startup: release reset, hold `prng_out_valid`=1.
  - `prng_start_reseed` is high for exactly 1 cycle (cycle 1).
  - No `req_ready` before cycle 1+WARMUP.
- Single job: requester 0 with pt=0, key=0.
  - XOR-reconstructed `rsp_data` = 128'h2e2b34ca59fa4c883b2c8aefd44be966.
  - `rsp_id`=0, `rsp_err`=0.
  - Exactly one `core_valid_in` pulse.
- Contention: both requesters held valid for 4 jobs.
  - Grants alternate 0,1,0,1.
  - `rsp_id` follows the same order.
- Backpressure: hold `rsp_ready`=0 for 10 cycles.
  - `rsp_valid` and `rsp_data` stay stable.
  - No new grant until the handshake.
- Reseed cadence with RESEED_EVERY=2: run 3 jobs.
  - The second reseed pulse occurs after the 2nd response handshake.
  - The 3rd grant is ≥WARMUP cycles later.
- Watchdog: suppress `core_cipher_valid`.
  - `rsp_err`=1 and `rsp_data`=0 after TIMEOUT cycles in WAIT.
  - After the handshake, `core_nrst` is low for 3 cycles, then a reseed pulse follows.
